usb_ep2_reader: RTL and testbench
=================================

# usb_ep2_reader

Front-end receive stage for the FX2 synchronous slave-FIFO port. Pulls one packet of 16-bit words out of endpoint EP2 into a local packet buffer, then presents the packet word-by-word on a valid/ready stream with length and last markers. The downstream consumer is the Wishbone SDRAM write stage; this block owns EP2 reads only and never drives USB data.

## Interface
Parameters:
- DATA_WIDTH, 16, USB word width
- MAXPKG, 256, buffer depth in words; the maximum packet length
- LOGMAXPKG, 8, log2(MAXPKG)

Ports:
- clk_i  in  1  USB_IFCLK domain clock; one clock only
- rst_i  in  1  asynchronous, active-high reset
- usb_data_i  in  DATA_WIDTH  FX2 FD bus (read direction)
- usb_flaga_i  in  1  EP2 not-empty, high = data available
- usb_slrd_o  out  1  FX2 SLRD, active low
- usb_sloe_o  out  1  FX2 SLOE, active low
- usb_addr_o  out  2  FIFOADR; 2'b00 (EP2) whenever this block is active
- busy_o  out  1  high in every state except IDLE
- pkt_data_o  out  DATA_WIDTH  stream word
- pkt_valid_o  out  1  stream word valid
- pkt_ready_i  in  1  consumer accepts word
- pkt_last_o  out  1  marks final word of packet, qualified by pkt_valid_o
- pkt_len_o  out  LOGMAXPKG+1  packet word count, 1..MAXPKG; stable throughout DRAIN

## Operation
- Reset values: usb_slrd_o=1, usb_sloe_o=1, usb_addr_o=2'b00, busy_o=0, pkt_valid_o=0, pkt_last_o=0, pkt_data_o=0, pkt_len_o=0; state IDLE; write/read pointers 0.
- States: IDLE, SELECT, READ, DRAIN.
- IDLE: outputs idle. usb_flaga_i=1 -> SELECT.
- SELECT (1 cycle): usb_sloe_o<=0, usb_addr_o<=2'b00, wr_ptr<=0 -> READ.
- READ: usb_slrd_o registered low while usb_flaga_i=1 and wr_ptr < MAXPKG-1 at the driving edge; otherwise high.
  - Capture rule: at each edge where usb_slrd_o==0 and usb_flaga_i==1, write usb_data_i to buf[wr_ptr] and increment wr_ptr.
  - Exit when wr_ptr reaches MAXPKG, or when usb_flaga_i==0 with slrd high. wr_ptr>0 -> DRAIN with pkt_len_o<=wr_ptr. wr_ptr==0 -> IDLE.
  - On exit: usb_slrd_o<=1, usb_sloe_o<=1.
- DRAIN: words are streamed in order buf[0..len-1]. pkt_last_o=1 exactly with word len-1. The handshake is taken when valid&ready. Unaccepted words hold data/last stable. After the last handshake -> IDLE, and pkt_valid_o drops the next cycle. No FX2 reads occur in DRAIN, even if usb_flaga_i=1.
- Width rules: wr_ptr and rd_ptr are LOGMAXPKG+1 bits, so a full packet of MAXPKG words is representable without wrap. Pointers never wrap within a packet.
- rst_i asserted mid-packet: the partial packet is discarded, all outputs return to reset values immediately, and the FX2 FIFO contents are untouched.

## Timing
- FLAGA high in IDLE -> SLOE low 1 cycle later (SELECT) -> first SLRD low 2 cycles after IDLE sees FLAGA.
- READ throughput: 1 word per clock while FLAGA stays high.
- The buffer has a synchronous 1-cycle read. pkt_valid_o rises 2 cycles after DRAIN entry (prefetch of word 0).
- With pkt_ready_i held high, throughput is 1 word per clock: no bubbles between words, via a prefetch/skid register.
- pkt_ready_i dropping mid-packet must not lose or duplicate words.
- busy_o deasserts in the same cycle the state returns to IDLE.

## Structure
- Shared package fx2_pkg:
  - state encoding
  - EP address constants: EP2=2'b00, EP6=2'b10
  - MAXPKG / LOGMAXPKG defaults
- One sub-module, pkt_buf: simple dual-port RAM, MAXPKG x DATA_WIDTH, one write port, one synchronous read port.
- FSM, pointers and stream output register live in usb_ep2_reader.

## Test plan
- FLAGA high for 5 words 0x0001..0x0005, then low; ready held 1 -> exactly 5 SLRD-low cycles; pkt_len_o=5; stream 0x0001..0x0005; last on 0x0005; busy_o low afterward.
- FLAGA held high with MAXPKG+10 words available -> exactly MAXPKG captured; pkt_len_o=256; SLRD stays high through DRAIN; remaining 10 words read as the next packet after IDLE.
- 8-word packet, pkt_ready_i toggling 1,0,0,1,... -> all 8 words delivered once, in order, with data stable while stalled.
- FLAGA pulses high for 1 cycle then low before any capture -> IDLE->SELECT->READ->IDLE; no stream output.
- rst_i asserted at word 3 of a 10-word read -> SLRD and SLOE go high immediately; valid stays 0; the next packet starts from wr_ptr=0 with correct data.
- FLAGA falls mid-burst for 1 cycle after 4 words -> packet ends with pkt_len_o=4; later words form a new packet.

Source files
------------

// File: rtl/fx2_pkg.sv
// Shared definitions for the FX2 slave-FIFO receive path.
// Holds the reader state encoding, FIFOADR endpoint constants and the
// default packet buffer geometry used by usb_ep2_reader and pkt_buf.
package fx2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_READ   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic [1:0] EP2 = 2'b00;
    localparam logic [1:0] EP6 = 2'b10;

    localparam int MAXPKG_DEF    = 256;
    localparam int LOGMAXPKG_DEF = 8;

endpackage

// File: rtl/pkt_buf.sv
// Packet buffer: simple dual-port RAM, one write port, one synchronous
// read port with read enable (rd_data holds while rd_en is low).
// Ports:
//   clk_i            USB_IFCLK
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr    read request, data appears on rd_data one clock later
//   rd_data          registered read data
module pkt_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int AW         = 8
) (
    input  logic                  clk_i,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/usb_ep2_reader.sv
// EP2 receive front end for the FX2 synchronous slave FIFO. Reads one
// packet of words from EP2 into pkt_buf, then streams it out on a
// valid/ready interface with length and last markers.
// Ports:
//   clk_i, rst_i              USB_IFCLK, async active-high reset
//   usb_data_i, usb_flaga_i   FX2 FD bus and EP2 not-empty flag
//   usb_slrd_o, usb_sloe_o    FX2 read strobe / output enable (active low)
//   usb_addr_o                FIFOADR, always EP2
//   busy_o                    high whenever the FSM is not IDLE
//   pkt_data_o/valid/ready/last, pkt_len_o   packet stream to the consumer
//
// state  | meaning
// IDLE   | waiting for EP2 not-empty
// SELECT | FIFOADR=EP2, SLOE asserted, write pointer cleared
// READ   | SLRD burst, one word captured per clock while FLAGA is high
// DRAIN  | buffered packet streamed out; no FX2 reads
module usb_ep2_reader
    import fx2_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAXPKG     = MAXPKG_DEF,
    parameter int LOGMAXPKG  = LOGMAXPKG_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] usb_data_i,
    input  logic                  usb_flaga_i,
    output logic                  usb_slrd_o,
    output logic                  usb_sloe_o,
    output logic [1:0]            usb_addr_o,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] pkt_data_o,
    output logic                  pkt_valid_o,
    input  logic                  pkt_ready_i,
    output logic                  pkt_last_o,
    output logic [LOGMAXPKG:0]    pkt_len_o
);

    localparam int PW = LOGMAXPKG + 1;
    localparam logic [PW-1:0] PTR_FULL = PW'(MAXPKG);

    state_t state_q, state_d;

    logic [PW-1:0]         wr_ptr, wr_nxt, rd_ptr;
    logic                  q_valid, q_last;
    logic [DATA_WIDTH-1:0] buf_q;
    logic                  capture, rd_en, out_load, out_fire;

    pkt_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAXPKG),
        .AW         (LOGMAXPKG)
    ) u_buf (
        .clk_i   (clk_i),
        .wr_en   (capture),
        .wr_addr (wr_ptr[LOGMAXPKG-1:0]),
        .wr_data (usb_data_i),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[LOGMAXPKG-1:0]),
        .rd_data (buf_q)
    );

    assign busy_o = (state_q != ST_IDLE);
    assign wr_nxt = wr_ptr + PW'(capture);

    // The RAM output register acts as the skid stage: it is only refilled
    // when empty or when its word moves into the output register, so a
    // stalled consumer never loses or repeats a word.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        rd_en    = 1'b0;
        out_load = 1'b0;
        out_fire = pkt_valid_o && pkt_ready_i;
        case (state_q)
            ST_IDLE: begin
                if (usb_flaga_i) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                capture = !usb_slrd_o && usb_flaga_i;
                // An empty FIFO ends the packet even if SLRD is still low;
                // FX2 ignores the strobe while FLAGA is low.
                if (wr_ptr == PTR_FULL || !usb_flaga_i) begin
                    state_d = (wr_ptr == '0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_load = q_valid && (!pkt_valid_o || pkt_ready_i);
                rd_en    = (rd_ptr != pkt_len_o) && (!q_valid || out_load);
                if (out_fire && pkt_last_o) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            usb_slrd_o  <= 1'b1;
            usb_sloe_o  <= 1'b1;
            usb_addr_o  <= EP2;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_valid     <= 1'b0;
            q_last      <= 1'b0;
            pkt_data_o  <= '0;
            pkt_valid_o <= 1'b0;
            pkt_last_o  <= 1'b0;
            pkt_len_o   <= '0;
        end else begin
            case (state_q)
                ST_SELECT: begin
                    usb_sloe_o <= 1'b0;
                    usb_addr_o <= EP2;
                    wr_ptr     <= '0;
                end
                ST_READ: begin
                    wr_ptr <= wr_nxt;
                    if (state_d != ST_READ) begin
                        usb_slrd_o <= 1'b1;
                        usb_sloe_o <= 1'b1;
                        rd_ptr     <= '0;
                        q_valid    <= 1'b0;
                        if (state_d == ST_DRAIN) pkt_len_o <= wr_ptr;
                    end else begin
                        // Stop strobing once the word being captured fills the buffer.
                        usb_slrd_o <= !(usb_flaga_i && (wr_nxt < PTR_FULL));
                    end
                end
                ST_DRAIN: begin
                    if (rd_en) begin
                        rd_ptr  <= rd_ptr + PW'(1);
                        q_last  <= (rd_ptr == (pkt_len_o - PW'(1)));
                        q_valid <= 1'b1;
                    end else if (out_load) begin
                        q_valid <= 1'b0;
                    end
                    if (out_load) begin
                        pkt_data_o  <= buf_q;
                        pkt_last_o  <= q_last;
                        pkt_valid_o <= 1'b1;
                    end else if (out_fire) begin
                        pkt_valid_o <= 1'b0;
                        pkt_last_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_ep2_reader.sv
module tb_usb_ep2_reader;

    localparam int DW        = 16;
    localparam int MAXPKG    = 256;
    localparam int LOGMAXPKG = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [DW-1:0]        usb_data_i = '0;
    logic                 usb_flaga_i = 1'b0;
    logic                 usb_slrd_o, usb_sloe_o;
    logic [1:0]           usb_addr_o;
    logic                 busy_o;
    logic [DW-1:0]        pkt_data_o;
    logic                 pkt_valid_o;
    logic                 pkt_ready_i = 1'b1;
    logic                 pkt_last_o;
    logic [LOGMAXPKG:0]   pkt_len_o;

    int checks   = 0;
    int failures = 0;

    // FX2 EP2 FIFO model and stream observations
    logic [DW-1:0] fifo[$];
    bit            gap   = 1'b0;
    bit            pulse = 1'b0;
    int            pops  = 0;
    int            cyc   = 0;
    int            valid_cycles = 0;
    logic [DW-1:0] got_data[$];
    bit            got_last[$];
    int            got_len[$];
    int            got_cyc[$];

    usb_ep2_reader #(
        .DATA_WIDTH (DW),
        .MAXPKG     (MAXPKG),
        .LOGMAXPKG  (LOGMAXPKG)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .usb_data_i  (usb_data_i),
        .usb_flaga_i (usb_flaga_i),
        .usb_slrd_o  (usb_slrd_o),
        .usb_sloe_o  (usb_sloe_o),
        .usb_addr_o  (usb_addr_o),
        .busy_o      (busy_o),
        .pkt_data_o  (pkt_data_o),
        .pkt_valid_o (pkt_valid_o),
        .pkt_ready_i (pkt_ready_i),
        .pkt_last_o  (pkt_last_o),
        .pkt_len_o   (pkt_len_o)
    );

    always #5 clk_i = ~clk_i;

    // FX2 pops a word at an edge where SLRD is low and the FIFO is not empty.
    always @(posedge clk_i) begin
        cyc++;
        if (!rst_i) begin
            if (usb_slrd_o === 1'b0 && usb_flaga_i === 1'b1 && fifo.size() > 0) begin
                fifo.delete(0);
                pops++;
            end
            if (pkt_valid_o === 1'b1) valid_cycles++;
            if (pkt_valid_o === 1'b1 && pkt_ready_i === 1'b1) begin
                got_data.push_back(pkt_data_o);
                got_last.push_back(pkt_last_o);
                got_len.push_back(int'(pkt_len_o));
                got_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clk_i) begin
        usb_flaga_i = ((fifo.size() > 0) && !gap) || pulse;
        usb_data_i  = (fifo.size() > 0) ? fifo[0] : '0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_obs();
        got_data.delete();
        got_last.delete();
        got_len.delete();
        got_cyc.delete();
        pops = 0;
        valid_cycles = 0;
    endtask

    // Waits for busy to rise and fall again; ok=0 if the budget expires.
    task automatic run_until_idle(input int budget, input bit rnd_ready, output bit ok);
        bit started;
        started = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            pkt_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (busy_o) started = 1'b1;
            else if (started) begin
                ok = 1'b1;
                break;
            end
        end
        pkt_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({usb_slrd_o, usb_sloe_o, usb_addr_o, busy_o, pkt_valid_o, pkt_last_o} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=1100000",
                     {usb_slrd_o, usb_sloe_o, usb_addr_o, busy_o, pkt_valid_o, pkt_last_o});
        end
        checks++;
        if (pkt_data_o !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", pkt_data_o);
        end
        checks++;
        if (pkt_len_o !== '0) begin
            failures++;
            $display("FAIL reset_len got=%0d want=0", pkt_len_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_short_packet();
        bit ok;
        clear_obs();
        for (int i = 1; i <= 5; i++) fifo.push_back(DW'(i));
        run_until_idle(200, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL short_timeout got=busy want=idle"); end
        checks++;
        if (pops != 5) begin failures++; $display("FAIL short_reads got=%0d want=5", pops); end
        checks++;
        if (got_data.size() != 5) begin
            failures++; $display("FAIL short_count got=%0d want=5", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 5; i++) begin
            checks++;
            if (got_data[i] !== DW'(i + 1) || got_last[i] != (i == 4) || got_len[i] != 5) begin
                failures++;
                $display("FAIL short_word%0d got=%h/last%0d/len%0d want=%h/last%0d/len5",
                         i, got_data[i], got_last[i], got_len[i], DW'(i + 1), (i == 4));
            end
        end
        if (got_cyc.size() == 5) begin
            checks++;
            if (got_cyc[4] - got_cyc[0] != 4) begin
                failures++; $display("FAIL short_bubbles got_span=%0d want=4", got_cyc[4] - got_cyc[0]);
            end
        end
        checks++;
        if (busy_o !== 1'b0 || pkt_valid_o !== 1'b0) begin
            failures++; $display("FAIL short_after got=busy%b/valid%b want=0/0", busy_o, pkt_valid_o);
        end
    endtask

    task automatic test_full_packet();
        logic [DW-1:0] exp[$];
        bit ok;
        int bad, nlast, badlen;
        clear_obs();
        for (int i = 0; i < MAXPKG + 10; i++) exp.push_back(DW'($urandom));
        foreach (exp[i]) fifo.push_back(exp[i]);
        run_until_idle(2000, 1'b0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL full_timeout got=busy want=idle"); end
        checks++;
        if (pops != MAXPKG || fifo.size() != 10) begin
            failures++; $display("FAIL full_reads got=%0d/left%0d want=%0d/left10", pops, fifo.size(), MAXPKG);
        end
        checks++;
        if (got_data.size() != MAXPKG) begin
            failures++; $display("FAIL full_count got=%0d want=%0d", got_data.size(), MAXPKG);
        end
        bad = 0; nlast = 0; badlen = 0;
        for (int i = 0; i < got_data.size() && i < MAXPKG; i++) begin
            if (got_data[i] !== exp[i]) bad++;
            if (got_last[i]) nlast++;
            if (got_len[i] != MAXPKG) badlen++;
        end
        checks++;
        if (bad != 0 || badlen != 0) begin
            failures++; $display("FAIL full_data got=bad%0d/badlen%0d want=0/0", bad, badlen);
        end
        checks++;
        if (nlast != 1 || got_last.size() != MAXPKG || !got_last[MAXPKG-1]) begin
            failures++; $display("FAIL full_last got=%0d_lasts want=1_at_end", nlast);
        end
        clear_obs();
        run_until_idle(400, 1'b0, ok);
        checks++;
        if (!ok || got_data.size() != 10) begin
            failures++; $display("FAIL rest_count got=%0d ok%0d want=10", got_data.size(), ok);
        end
        bad = 0;
        for (int i = 0; i < got_data.size() && i < 10; i++) begin
            if (got_data[i] !== exp[MAXPKG + i] || got_len[i] != 10 || got_last[i] != (i == 9)) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rest_data got=bad%0d want=0", bad); end
    endtask

    task automatic test_ready_toggle();
        logic [DW-1:0] exp[$];
        logic [DW-1:0] pd;
        bit started, done, pv, pr, pl;
        int stalls, bad;
        started = 1'b0; done = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        stalls = 0; bad = 0;
        clear_obs();
        for (int i = 0; i < 8; i++) exp.push_back(DW'($urandom));
        foreach (exp[i]) fifo.push_back(exp[i]);
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk_i);
            if (pv && !pr) begin
                stalls++;
                checks++;
                if ({pkt_valid_o, pkt_last_o, pkt_data_o} !== {1'b1, pl, pd}) begin
                    failures++;
                    $display("FAIL stall_hold got=v%b/l%b/%h want=v1/l%b/%h",
                             pkt_valid_o, pkt_last_o, pkt_data_o, pl, pd);
                end
            end
            if (busy_o) started = 1'b1;
            else if (started) done = 1'b1;
            pkt_ready_i = ((k % 3) == 0);
            pv = pkt_valid_o; pr = pkt_ready_i; pl = pkt_last_o; pd = pkt_data_o;
        end
        pkt_ready_i = 1'b1;
        checks++;
        if (!done || stalls == 0) begin
            failures++; $display("FAIL toggle_run got=done%0d/stalls%0d want=1/>0", done, stalls);
        end
        checks++;
        if (got_data.size() != 8) begin
            failures++; $display("FAIL toggle_count got=%0d want=8", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            if (got_data[i] !== exp[i] || got_last[i] != (i == 7)) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL toggle_data got=bad%0d want=0", bad); end
    endtask

    task automatic test_flaga_pulse();
        int busy_cnt, sloe_lo;
        busy_cnt = 0; sloe_lo = 0;
        clear_obs();
        @(posedge clk_i); #1 pulse = 1'b1;
        @(posedge clk_i); #1 pulse = 1'b0;
        repeat (8) begin
            @(negedge clk_i);
            if (busy_o) busy_cnt++;
            if (!usb_sloe_o) sloe_lo++;
        end
        checks++;
        if (busy_cnt != 2 || sloe_lo != 1) begin
            failures++; $display("FAIL pulse_seq got=busy%0d/sloe%0d want=2/1", busy_cnt, sloe_lo);
        end
        checks++;
        if (pops != 0 || valid_cycles != 0 || got_data.size() != 0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL pulse_quiet got=reads%0d/valid%0d/busy%b want=0/0/0", pops, valid_cycles, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] exp[$];
        bit ok;
        int bad;
        clear_obs();
        for (int i = 0; i < 10; i++) exp.push_back(DW'($urandom));
        foreach (exp[i]) fifo.push_back(exp[i]);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i); #1;
            if (pops == 3) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_wait got=reads%0d want=3", pops); end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({usb_slrd_o, usb_sloe_o, pkt_valid_o, busy_o} !== 4'b1100) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b want=1100", {usb_slrd_o, usb_sloe_o, pkt_valid_o, busy_o});
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        checks++;
        if (fifo.size() != 7 || valid_cycles != 0) begin
            failures++; $display("FAIL rstmid_fifo got=left%0d/valid%0d want=7/0", fifo.size(), valid_cycles);
        end
        clear_obs();
        run_until_idle(200, 1'b0, ok);
        bad = 0;
        for (int i = 0; i < got_data.size() && i < 7; i++) begin
            if (got_data[i] !== exp[3 + i] || got_len[i] != 7 || got_last[i] != (i == 6)) bad++;
        end
        checks++;
        if (!ok || got_data.size() != 7 || bad != 0) begin
            failures++; $display("FAIL rstmid_next got=n%0d/bad%0d want=7/0", got_data.size(), bad);
        end
    endtask

    task automatic test_flaga_gap();
        logic [DW-1:0] exp[$];
        bit ok;
        int bad;
        clear_obs();
        for (int i = 0; i < 10; i++) exp.push_back(DW'($urandom));
        foreach (exp[i]) fifo.push_back(exp[i]);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i); #1;
            if (pops == 4) begin ok = 1'b1; break; end
        end
        gap = 1'b1;
        @(posedge clk_i); #1 gap = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL gap_wait got=reads%0d want=4", pops); end
        run_until_idle(200, 1'b0, ok);
        bad = 0;
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            if (got_data[i] !== exp[i] || got_len[i] != 4 || got_last[i] != (i == 3)) bad++;
        end
        checks++;
        if (!ok || got_data.size() != 4 || bad != 0 || pops != 4) begin
            failures++;
            $display("FAIL gap_pkt1 got=n%0d/bad%0d/reads%0d want=4/0/4", got_data.size(), bad, pops);
        end
        clear_obs();
        run_until_idle(200, 1'b0, ok);
        bad = 0;
        for (int i = 0; i < got_data.size() && i < 6; i++) begin
            if (got_data[i] !== exp[4 + i] || got_len[i] != 6 || got_last[i] != (i == 5)) bad++;
        end
        checks++;
        if (!ok || got_data.size() != 6 || bad != 0) begin
            failures++; $display("FAIL gap_pkt2 got=n%0d/bad%0d want=6/0", got_data.size(), bad);
        end
    endtask

    task automatic test_random_packets();
        logic [DW-1:0] exp[$];
        bit ok;
        int len, bad;
        for (int p = 0; p < 4; p++) begin
            exp.delete();
            clear_obs();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) exp.push_back(DW'($urandom));
            foreach (exp[i]) fifo.push_back(exp[i]);
            run_until_idle(1000, 1'b1, ok);
            bad = 0;
            for (int i = 0; i < got_data.size() && i < len; i++) begin
                if (got_data[i] !== exp[i] || got_len[i] != len || got_last[i] != (i == len - 1)) bad++;
            end
            checks++;
            if (!ok || got_data.size() != len || bad != 0 || pops != len) begin
                failures++;
                $display("FAIL random_pkt%0d got=n%0d/bad%0d/reads%0d want=%0d/0/%0d",
                         p, got_data.size(), bad, pops, len, len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_packet();
        test_full_packet();
        test_ready_toggle();
        test_flaga_pulse();
        test_reset_mid();
        test_flaga_gap();
        test_random_packets();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
